// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS BCD timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX     = 4'd9;
  localparam int   ALARM_TICKS  = 8;

  // Bit offsets of each digit inside the packed 16-bit count.
  localparam int MIN_TENS_LSB = 12;
  localparam int MIN_ONES_LSB = 8;
  localparam int SEC_TENS_LSB = 4;
  localparam int SEC_ONES_LSB = 0;

  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit counting 0..MAX with wrap, parallel load and carry/borrow out.
module bcd_digit
  import timer_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  bcd_t load_val,
  input  logic en,
  input  logic dn,
  output bcd_t q,
  output logic co
);

  logic wrap;

  assign wrap = dn ? (q == 4'd0) : (q == MAX);
  assign co   = en & wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      if (wrap) q <= dn ? MAX : 4'd0;
      else      q <= dn ? q - 4'd1 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_timer.sv
// Tick-enabled MM:SS up/down timer with start/stop/load and done pulse; TIMER_ALARM_EN adds an 8-tick alarm.
// Latency: digits step on the edge sampling the final tick of a step; control outputs change on the sampling edge.
// Backpressure: none; tick is an enable, every input is sampled every clk.
module bcd_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_STEP = 100,
  parameter int MAX_MIN        = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        load,
  input  logic        dir,
  input  logic [15:0] load_val,
  output logic [15:0] digits,
  output logic        running,
  output logic        done
`ifdef TIMER_ALARM_EN
  ,
  output logic        alarm
`endif
);

  localparam logic [7:0]  MAX_MIN_BCD = to_bcd8(MAX_MIN);
  localparam logic [15:0] LIMIT       = {MAX_MIN_BCD, SEC_TENS_MAX, ONES_MAX};

  state_t      state;
  logic [11:0] presc;
  logic        last_tick;
  logic        at_limit;
  logic        enter_done;
  logic        step;

  bcd_t        ld_mt, ld_mo, ld_st, ld_so;
  logic [15:0] ld_clean;

  bcd_t        q_mt, q_mo, q_st, q_so;
  logic        co_so, co_st, co_mo, co_mt;

  // Minutes are clamped after per-digit clamping so the BCD pair compares as a plain number.
  always_comb begin
    ld_mt = clamp_digit(load_val[MIN_TENS_LSB +: 4], ONES_MAX);
    ld_mo = clamp_digit(load_val[MIN_ONES_LSB +: 4], ONES_MAX);
    ld_st = clamp_digit(load_val[SEC_TENS_LSB +: 4], SEC_TENS_MAX);
    ld_so = clamp_digit(load_val[SEC_ONES_LSB +: 4], ONES_MAX);
    if ({ld_mt, ld_mo} > MAX_MIN_BCD) {ld_mt, ld_mo} = MAX_MIN_BCD;
    ld_clean = {ld_mt, ld_mo, ld_st, ld_so};
  end

  assign digits     = {q_mt, q_mo, q_st, q_so};
  assign last_tick  = (presc == 12'(TICKS_PER_STEP - 1));
  assign at_limit   = dir ? (digits == 16'h0000) : (digits == LIMIT);
  assign enter_done = (state == RUN) && !load && !stop && at_limit;
  assign step       = (state == RUN) && !load && !stop && !at_limit && tick && last_tick;

  bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .load(load), .load_val(ld_clean[SEC_ONES_LSB +: 4]),
    .en(step), .dn(dir), .q(q_so), .co(co_so)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .load(load), .load_val(ld_clean[SEC_TENS_LSB +: 4]),
    .en(co_so), .dn(dir), .q(q_st), .co(co_st)
  );

  bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .load(load), .load_val(ld_clean[MIN_ONES_LSB +: 4]),
    .en(co_st), .dn(dir), .q(q_mo), .co(co_mo)
  );

  // The limit check stops stepping before the minutes tens could ever wrap.
  bcd_digit #(.MAX(ONES_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .load(load), .load_val(ld_clean[MIN_TENS_LSB +: 4]),
    .en(co_mo), .dn(dir), .q(q_mt), .co(co_mt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state   <= IDLE;
        presc   <= '0;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (enter_done) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (tick) begin
              presc <= last_tick ? 12'd0 : presc + 12'd1;
            end
          end
          PAUSE: begin
            if (start && !stop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TIMER_ALARM_EN
  logic [3:0] alarm_cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else if (enter_done) begin
      alarm     <= 1'b1;
      alarm_cnt <= '0;
    end else if (alarm && tick) begin
      if (alarm_cnt == 4'(ALARM_TICKS - 1)) alarm <= 1'b0;
      alarm_cnt <= alarm_cnt + 4'd1;
    end
  end
`endif

  logic unused_co;
  assign unused_co = co_mt;

endmodule

// File: tb/tb_bcd_timer.sv
// Scoreboard bench: two timer instances share stimulus, a total-seconds model predicts each clk.
module tb_bcd_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tick, start, stop, load, dir;
  logic [15:0] load_val;
  logic [15:0] dig1, dig4;
  logic        run1, run4, done1, done4;
`ifdef TIMER_ALARM_EN
  logic        alarm1, alarm4;
`endif

  bcd_timer #(.TICKS_PER_STEP(1), .MAX_MIN(99)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .load(load),
    .dir(dir), .load_val(load_val), .digits(dig1), .running(run1), .done(done1)
`ifdef TIMER_ALARM_EN
    , .alarm(alarm1)
`endif
  );

  bcd_timer #(.TICKS_PER_STEP(4), .MAX_MIN(12)) u_dut4 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .load(load),
    .dir(dir), .load_val(load_val), .digits(dig4), .running(run4), .done(done4)
`ifdef TIMER_ALARM_EN
    , .alarm(alarm4)
`endif
  );

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  typedef struct {
    int st;
    int presc;
    int secs;
    bit running;
    bit done;
    bit alarm;
    int acnt;
  } mdl_t;

  typedef struct {
    logic [15:0] digits;
    bit          running;
    bit          done;
    bit          alarm;
  } exp_t;

  mdl_t m1, m4;
  exp_t q1[$], q4[$];
  exp_t e1, e4;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit          dir_v;
  logic [15:0] lv_v;

  function automatic int sanitize(input logic [15:0] v, input int maxm);
    int mt, mo, st, so, m;
    mt = (v[15:12] > 4'd9) ? 9 : int'(v[15:12]);
    mo = (v[11:8]  > 4'd9) ? 9 : int'(v[11:8]);
    st = (v[7:4]   > 4'd5) ? 5 : int'(v[7:4]);
    so = (v[3:0]   > 4'd9) ? 9 : int'(v[3:0]);
    m  = mt * 10 + mo;
    if (m > maxm) m = maxm;
    return m * 60 + st * 10 + so;
  endfunction

  function automatic mdl_t model_next(input mdl_t s, input int tps, input int maxm,
                                      input bit r, input bit t, input bit go,
                                      input bit halt, input bit ld, input bit dn,
                                      input logic [15:0] lv);
    mdl_t n;
    n      = s;
    n.done = 1'b0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (ld) begin
      n.st = S_IDLE; n.presc = 0; n.secs = sanitize(lv, maxm);
      n.running = 1'b0; n.alarm = 1'b0; n.acnt = 0;
      return n;
    end
    if (s.alarm && t) begin
      n.acnt = s.acnt + 1;
      if (n.acnt == 8) n.alarm = 1'b0;
    end
    case (s.st)
      S_IDLE: if (go && !halt) begin n.st = S_RUN; n.presc = 0; n.running = 1'b1; end
      S_PAUSE: if (go && !halt) begin n.st = S_RUN; n.running = 1'b1; end
      S_RUN: begin
        if (halt) begin
          n.st = S_PAUSE; n.running = 1'b0;
        end else if ((dn && s.secs == 0) || (!dn && s.secs == maxm * 60 + 59)) begin
          n.st = S_DONE; n.running = 1'b0; n.done = 1'b1; n.alarm = 1'b1; n.acnt = 0;
        end else if (t) begin
          if (s.presc == tps - 1) begin
            n.presc = 0;
            n.secs  = dn ? s.secs - 1 : s.secs + 1;
          end else begin
            n.presc = s.presc + 1;
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic exp_t to_exp(input mdl_t s);
    exp_t e;
    int m, sc;
    logic [3:0] a, b, c, d;
    m  = s.secs / 60;
    sc = s.secs % 60;
    a  = 4'(m / 10);
    b  = 4'(m % 10);
    c  = 4'(sc / 10);
    d  = 4'(sc % 10);
    e.digits  = {a, b, c, d};
    e.running = s.running;
    e.done    = s.done;
    e.alarm   = s.alarm;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit t, input bit go, input bit halt, input bit ld);
    @(negedge clk);
    rst = r; tick = t; start = go; stop = halt; load = ld;
    dir = dir_v; load_val = lv_v;
    m1 = model_next(m1, 1, 99, r, t, go, halt, ld, dir_v, lv_v);
    m4 = model_next(m4, 4, 12, r, t, go, halt, ld, dir_v, lv_v);
    q1.push_back(to_exp(m1));
    q4.push_back(to_exp(m4));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    lv_v = v;
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are presented every clk, so each edge retires one expectation.
  always @(posedge clk) begin
    #1;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("d1.digits",  dig1,        e1.digits);
      chk("d1.running", 16'(run1),   16'(e1.running));
      chk("d1.done",    16'(done1),  16'(e1.done));
`ifdef TIMER_ALARM_EN
      chk("d1.alarm",   16'(alarm1), 16'(e1.alarm));
`endif
    end
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      chk("d4.digits",  dig4,        e4.digits);
      chk("d4.running", 16'(run4),   16'(e4.running));
      chk("d4.done",    16'(done4),  16'(e4.done));
`ifdef TIMER_ALARM_EN
      chk("d4.alarm",   16'(alarm4), 16'(e4.alarm));
`endif
    end
  end

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    dir = 1'b0; load_val = 16'h0;
    dir_v = 1'b0; lv_v = 16'h0;
    m1 = '{default: 0};
    m4 = '{default: 0};

    // Reset with start/tick asserted must be ignored.
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("rst.digits", dig1, 16'h0000);
    chk("rst.running", 16'(run1), 16'h0);
    chk("rst.done", 16'(done1), 16'h0);

    // Up-count carry chain across seconds and minutes.
    dir_v = 1'b0;
    do_load(16'h0958);
    cyc(0, 0, 1, 0, 0);
    ticks(3);
    settle();
    chk("carry.digits", dig1, 16'h1001);
    chk("carry.running", 16'(run1), 16'h1);

    // Down to zero, done pulse, then hold.
    dir_v = 1'b1;
    do_load(16'h0002);
    cyc(0, 0, 1, 0, 0);
    ticks(2);
    idle(2);
    ticks(3);
    settle();
    chk("down.digits", dig1, 16'h0000);
    chk("down.running", 16'(run1), 16'h0);

    // Prescaler holds while paused: exactly one step on the /4 instance.
    dir_v = 1'b0;
    do_load(16'h0100);
    cyc(0, 0, 1, 0, 0);
    ticks(2);
    cyc(0, 0, 0, 1, 0);
    ticks(5);
    cyc(0, 0, 1, 0, 0);
    ticks(2);
    settle();
    chk("pause.digits", dig4, 16'h0101);

    // Load sanitising and start+stop together.
    do_load(16'hA7F3);
    settle();
    chk("sanit.d1", dig1, 16'h9753);
    chk("sanit.d4", dig4, 16'h1253);
    cyc(0, 0, 1, 1, 0);
    settle();
    chk("startstop.running", 16'(run1), 16'h0);

    // Up limit on the MAX_MIN=12 instance.
    dir_v = 1'b0;
    do_load(16'h1258);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0);
    settle();
    chk("uplim.digits", dig4, 16'h1259);
    chk("uplim.running", 16'(run4), 16'h0);

    // Down-start at zero completes immediately; alarm runs 8 ticks.
    dir_v = 1'b1;
    do_load(16'h0000);
    cyc(0, 0, 1, 0, 0);
    idle(2);
    ticks(10);
    // Alarm cleared by load mid-way.
    do_load(16'h0001);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    ticks(3);
    do_load(16'h0030);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, t, go, halt, ld;
      if ($urandom_range(0, 19) == 0) dir_v = ~dir_v;
      case ($urandom_range(0, 3))
        0: lv_v = 16'($urandom);
        1: lv_v = 16'h0003;
        2: lv_v = 16'h1256;
        default: lv_v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      endcase
      r    = ($urandom_range(0, 299) == 0);
      t    = ($urandom_range(0, 1) == 1);
      go   = ($urandom_range(0, 7) == 0);
      halt = ($urandom_range(0, 24) == 0);
      ld   = ($urandom_range(0, 59) == 0);
      cyc(r, t, go, halt, ld);
    end

    idle(2);
    repeat (4) @(posedge clk);
    #3;
    n_checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0", q1.size(), q4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
